// File: rtl/usr_pkg.sv
// usr_pkg: shared types and constants for the universal shift register.
//   MODE_*      : 2-bit manual operation codes applied while idle.
//   usr_state_e : burst controller state encoding.
package usr_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } usr_state_e;

endpackage

// File: rtl/usr_burst_ctrl.sv
// usr_burst_ctrl: burst sequencing for univ_shift_reg.
//   state | meaning
//   IDLE  | manual modes active; start launches a burst
//   BURST | register shifts right once per enabled cycle, WIDTH shifts total
// Ports:
//   clk, rst            : clock, async active-high reset
//   en, start           : clock enable, burst request
//   idle                : controller in IDLE (manual modes allowed)
//   burst_load          : this edge loads d and enters BURST
//   burst_shift         : this edge performs a burst shift
//   busy, done          : registered handshake outputs
module usr_burst_ctrl
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic start,
   output logic idle,
   output logic burst_load,
   output logic burst_shift,
   output logic busy,
   output logic done
);

   localparam int CW = $clog2(WIDTH + 1);

   usr_state_e     state;
   logic [CW-1:0]  cnt;
   logic           last;

   assign idle        = (state == IDLE);
   assign burst_load  = en & idle & start;
   assign burst_shift = en & (state == BURST);
   assign last        = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         // done is a single-cycle pulse: it clears on the next edge even with en low
         done <= burst_shift & last;
         if (burst_load) begin
            state <= BURST;
            cnt   <= '0;
            busy  <= 1'b1;
         end else if (burst_shift) begin
            if (last) begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with hold / shift right /
// shift left / parallel load and an automatic LSB-first burst mode.
// Optional build macro: USR_ROTATE_EN -- shifts rotate instead of taking sin,
// so a completed burst leaves q equal to the loaded word.
// Ports:
//   clk, rst  : clock, async active-high reset (q <= RESET_VAL)
//   en        : clock enable; freezes all state when low
//   mode      : manual operation while idle (see usr_pkg MODE_*)
//   d, sin    : parallel load data, serial input
//   start     : burst request (has priority over mode)
//   q, sout   : register contents, serial output (q[0])
//   busy/done : burst in progress / one-cycle completion pulse
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   logic             idle;
   logic             burst_load;
   logic             burst_shift;
   logic [WIDTH-1:0] q_shr;
   logic [WIDTH-1:0] q_shl;
   logic [WIDTH-1:0] q_nxt;

   usr_burst_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .start       (start),
      .idle        (idle),
      .burst_load  (burst_load),
      .burst_shift (burst_shift),
      .busy        (busy),
      .done        (done)
   );

`ifdef USR_ROTATE_EN
   assign q_shr = {q[0], q[WIDTH-1:1]};
   assign q_shl = {q[WIDTH-2:0], q[WIDTH-1]};
`else
   assign q_shr = {sin, q[WIDTH-1:1]};
   assign q_shl = {q[WIDTH-2:0], sin};
`endif

   always_comb begin
      q_nxt = q;
      if (burst_load) begin
         q_nxt = d;
      end else if (burst_shift) begin
         q_nxt = q_shr;
      end else if (en && idle) begin
         case (mode)
            MODE_SHR:  q_nxt = q_shr;
            MODE_SHL:  q_nxt = q_shl;
            MODE_LOAD: q_nxt = d;
            default:   q_nxt = q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= RESET_VAL;
      else     q <= q_nxt;
   end

   assign sout = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

   localparam int W = 8;
`ifdef USR_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [1:0]   mode;
   logic [W-1:0] d;
   logic         sin;
   logic         start;
   logic [W-1:0] q;
   logic         sout;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .d     (d),
      .sin   (sin),
      .start (start),
      .q     (q),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mode = 2'b00; d = '0; sin = 1'b0; start = 1'b0;
      #2;
      checks++;
      if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
         errors++;
         $display("FAIL reset: q=%h busy=%b done=%b sout=%b required q=00 busy=0 done=0 sout=0",
                  q, busy, done, sout);
      end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_manual();
      logic [W-1:0] exp_q [0:5];
      exp_q[0] = 8'hA5; exp_q[1] = 8'hD2; exp_q[2] = 8'hE9;
      exp_q[3] = 8'h81; exp_q[4] = 8'h02; exp_q[5] = 8'h02;
      en = 1'b1; start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: begin mode = 2'b11; d = 8'hA5; end
            1: begin mode = 2'b01; sin = 1'b1; end
            2: begin mode = 2'b01; sin = 1'b1; end
            3: begin mode = 2'b11; d = 8'h81; end
            4: begin mode = 2'b10; sin = 1'b0; end
            default: begin mode = 2'b00; sin = 1'b1; end
         endcase
         step();
         checks++;
         if (q !== exp_q[i]) begin
            errors++;
            $display("FAIL manual[%0d]: q=%h required %h", i, q, exp_q[i]);
         end
      end
      // en low blocks a load
      en = 1'b0; mode = 2'b11; d = 8'h5A;
      step();
      checks++;
      if (q !== 8'h02) begin
         errors++;
         $display("FAIL manual_en_low: q=%h required 02", q);
      end
      en = 1'b1; mode = 2'b00;
   endtask

   task automatic test_burst();
      logic [W-1:0] exp;
      logic [W-1:0] word;
      word = 8'hC3;
      en = 1'b1; mode = 2'b00; sin = 1'b0; d = word; start = 1'b1;
      step();
      start = 1'b0;
      exp = word;
      checks++;
      if (busy !== 1'b1 || sout !== word[0] || q !== word) begin
         errors++;
         $display("FAIL burst_start: busy=%b sout=%b q=%h required busy=1 sout=%b q=%h",
                  busy, sout, q, word[0], word);
      end
      for (int k = 1; k < W; k++) begin
         step();
         exp = {ROT ? exp[0] : 1'b0, exp[W-1:1]};
         checks++;
         if (sout !== word[k] || busy !== 1'b1 || done !== 1'b0 || q !== exp) begin
            errors++;
            $display("FAIL burst_shift[%0d]: sout=%b busy=%b done=%b q=%h required sout=%b busy=1 done=0 q=%h",
                     k, sout, busy, done, q, word[k], exp);
         end
      end
      step();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || q !== (ROT ? word : 8'h00)) begin
         errors++;
         $display("FAIL burst_done: done=%b busy=%b q=%h required done=1 busy=0 q=%h",
                  done, busy, q, ROT ? word : 8'h00);
      end
      en = 1'b0;
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL burst_done_clear: done=%b busy=%b required 0 0", done, busy);
      end
      en = 1'b1;
   endtask

   task automatic test_freeze();
      logic [W-1:0] exp;
      int           edges;
      bit           seen;
      exp = 8'hC3;
      en = 1'b1; sin = 1'b0; d = 8'hC3; start = 1'b1; mode = 2'b00;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         exp = {ROT ? exp[0] : 1'b0, exp[W-1:1]};
      end
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mode = 2'(k + 1); start = k[0]; d = 8'hFF;
         step();
         checks++;
         if (q !== exp || sout !== exp[0] || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL freeze[%0d]: q=%h sout=%b busy=%b done=%b required q=%h sout=%b busy=1 done=0",
                     k, q, sout, busy, done, exp, exp[0]);
         end
      end
      en = 1'b1; mode = 2'b11; start = 1'b1; d = 8'hFF;
      seen = 1'b0; edges = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (k == 4) start = 1'b0;
         step();
         edges++;
         if (!done) exp = {ROT ? exp[0] : 1'b0, exp[W-1:1]};
         else begin
            exp = {ROT ? exp[0] : 1'b0, exp[W-1:1]};
            seen = 1'b1;
         end
         if (!seen) begin
            checks++;
            if (q !== exp) begin
               errors++;
               $display("FAIL freeze_resume[%0d]: q=%h required %h", k, q, exp);
            end
         end
      end
      start = 1'b0; mode = 2'b00;
      checks++;
      if (!seen || edges != 5) begin
         errors++;
         $display("FAIL freeze_done_delay: seen=%b edges_after_resume=%0d required 1 and 5", seen, edges);
      end
      checks++;
      if (q !== (ROT ? 8'hC3 : 8'h00)) begin
         errors++;
         $display("FAIL freeze_final_q: q=%h required %h", q, ROT ? 8'hC3 : 8'h00);
      end
   endtask

   task automatic test_back_to_back();
      en = 1'b1; mode = 2'b00; sin = 1'b1; d = 8'h3C; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < W; k++) step();
      checks++;
      if (done !== 1'b1 || q !== (ROT ? 8'h3C : 8'hFF)) begin
         errors++;
         $display("FAIL sin_fill_done: done=%b q=%h required done=1 q=%h",
                  done, q, ROT ? 8'h3C : 8'hFF);
      end
      d = 8'h5A; start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h5A) begin
         errors++;
         $display("FAIL back_to_back: busy=%b done=%b q=%h required busy=1 done=0 q=5a",
                  busy, done, q);
      end
      for (int k = 0; k < 3; k++) step();
      rst = 1'b1;
      #1;
      checks++;
      if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_burst: q=%h busy=%b done=%b sout=%b required 00 0 0 0",
                  q, busy, done, sout);
      end
      step();
      rst = 1'b0; sin = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || q !== 8'h00) begin
         errors++;
         $display("FAIL reset_abandon: busy=%b q=%h required 0 00", busy, q);
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_burst();
      test_freeze();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
